stim_sequencer: RTL and testbench
=================================

Name: stim_sequencer

Overview:
- Upstream stimulus generator for the AES trojan-benchmark top level.
- Drives its `state_change` and `key_change` enables with programmable, evenly spaced single-cycle pulses, so the state and key counters advance in a controlled sequence.
- Provides a start/busy/done handshake and a pulse counter, so a bench or host controller can run fixed-length encryption campaigns.

Parameters:
- CNT_W, 32, width of the vector count and issued-pulse counter
- GAP_W, 8, width of the inter-pulse gap field
- KEY_W, 16, width of the key-change interval field

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- start  in  1  request a campaign; sampled only in IDLE
- abort  in  1  synchronous cancel of a running campaign
- num_vectors  in  CNT_W  number of state_change pulses to issue; latched on accepted start
- gap  in  GAP_W  idle cycles between pulses; pulse period P = gap+1; latched on start
- key_every  in  KEY_W  key_change on every key_every-th pulse; 0 = never; latched on start
- state_change  out  1  registered single-cycle state-advance pulse
- key_change  out  1  registered single-cycle key-advance pulse
- busy  out  1  campaign in progress
- done  out  1  single-cycle completion pulse
- vec_cnt  out  CNT_W  pulses issued in current/last campaign

Behaviour:
- Reset (rst=0, async): FSM=IDLE; state_change, key_change, busy and done all 0; vec_cnt=0; latched config cleared.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE, start=1, num_vectors!=0 at edge 0:
  - latch the config; clear vec_cnt; go to ISSUE.
  - The first state_change is high in cycle 1 (1-cycle latency), with vec_cnt=1.
- IDLE, start=1, num_vectors==0: go to DONE. done=1 in cycle 1, no pulses, vec_cnt=0.
- ISSUE (one cycle), pulse n:
  - state_change=1 and vec_cnt=n.
  - key_change=1 in the same cycle iff key_every!=0 and n mod key_every==0. Use a reload down-counter, not a divider.
  - Next state: if gap==0, stay in ISSUE while n<N, so pulses are back-to-back; else go to WAIT for exactly gap cycles.
- WAIT: gap timer counts down. At expiry go to ISSUE if vec_cnt<N, else DONE.
  - A gap follows the last pulse too, so done lands at cycle 1+N*P.
- Pulse n is therefore visible in cycle 1+(n-1)*P.
- DONE: done=1 and busy=0 for one cycle, then IDLE. vec_cnt holds N until the next accepted start.
- busy=1 from cycle 1 through cycle N*P inclusive.
- start while not IDLE is ignored. Config inputs may change freely after acceptance.
- abort=1 in ISSUE, WAIT or DONE: go to IDLE at that edge.
  - From that edge state_change, key_change, busy and done are all 0; no done pulse is generated.
  - vec_cnt holds the count issued so far.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, start is not accepted.
- state_change and key_change are never high outside ISSUE.
- Widths: N up to 2^CNT_W-1; counters never wrap within a campaign. Compare using full-width unsigned values.
- Reset deasserted mid-campaign restarts cleanly in IDLE; reset asserted mid-campaign clears outputs immediately (async).

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3) and default widths.
- One sub-module: stim_period_timer, a loadable down-counter (load value, enable, expiry flag). It is instantiated twice: once for the gap and once for the key_every interval.

Test Plan:
- Reset: rst=0 mid-campaign (N=10, gap=3) -> all outputs 0 immediately; after release, FSM idle and vec_cnt=0.
- N=4, gap=2, key_every=0 -> state_change in cycles 1,4,7,10; key_change never; done in cycle 13; busy high cycles 1..12; vec_cnt=4.
- N=5, gap=0, key_every=2 -> state_change in cycles 1..5 back-to-back; key_change in cycles 2,4; done in cycle 6.
- N=0 -> done in cycle 1; no pulses; busy never high.
- N=100, gap=1, abort at cycle 7 -> pulses in cycles 1,3,5 only; busy=0 from cycle 7; no done; vec_cnt=3.
- start re-pulsed during busy (N=3, gap=1) -> ignored: exactly 3 pulses, one done. A new start in the cycle after done is accepted and vec_cnt restarts at 1.

Source files
------------

// File: rtl/stim_sequencer_pkg.sv
// Shared definitions for the stimulus sequencer: FSM encoding and default widths.
package stim_sequencer_pkg;

    localparam int unsigned CntWDefault = 32;
    localparam int unsigned GapWDefault = 8;
    localparam int unsigned KeyWDefault = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/stim_period_timer.sv
// Loadable down-counter with an expiry flag (count at zero). Load has priority over
// decrement; decrement stops at zero.
module stim_period_timer
    import stim_sequencer_pkg::*;
#(
    parameter int unsigned W = GapWDefault
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Counter register: load, else count down while non-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: issues N evenly spaced state_change pulses, with key_change on
// every key_every-th pulse, under a start/busy/done handshake with abort.
module stim_sequencer
    import stim_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault,
    parameter int unsigned GAP_W = GapWDefault,
    parameter int unsigned KEY_W = KeyWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [GAP_W-1:0] gap,
    input  logic [KEY_W-1:0] key_every,
    output logic             state_change,
    output logic             key_change,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt
);

    seq_state_e state_q, state_d;

    logic [CNT_W-1:0] num_q, vec_cnt_q, vec_cnt_d;
    logic [GAP_W-1:0] gap_q;
    logic [KEY_W-1:0] key_every_q;

    logic accept, next_pulse, issue_key, more_left;
    logic gap_load, gap_en, gap_expired;
    logic [GAP_W-1:0] gap_load_val;
    logic key_load, key_en, key_expired;
    logic [KEY_W-1:0] key_load_val;

    logic sc_d, kc_d, busy_d, done_d;
    logic sc_q, kc_q, busy_q, done_q;

    // Gap timer: holds remaining WAIT cycles minus one.
    stim_period_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .en       (gap_en),
        .expired  (gap_expired)
    );

    // Key timer: holds pulses remaining before the next keyed pulse (zero = next is keyed).
    stim_period_timer #(.W(KEY_W)) u_key_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (key_load),
        .load_val (key_load_val),
        .en       (key_en),
        .expired  (key_expired)
    );

    // State, config and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            num_q       <= '0;
            gap_q       <= '0;
            key_every_q <= '0;
            vec_cnt_q   <= '0;
            sc_q        <= 1'b0;
            kc_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            sc_q      <= sc_d;
            kc_q      <= kc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (accept) begin
                num_q       <= num_vectors;
                gap_q       <= gap;
                key_every_q <= key_every;
            end
        end
    end

    // Next-state, timer control and pulse counting.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        next_pulse   = 1'b0;
        issue_key    = 1'b0;
        gap_load     = 1'b0;
        gap_load_val = '0;
        gap_en       = 1'b0;
        key_load     = 1'b0;
        key_load_val = '0;
        key_en       = 1'b0;
        more_left    = (vec_cnt_q < num_q);
        vec_cnt_d    = vec_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    vec_cnt_d = '0;
                    if (num_vectors != '0) begin
                        // Pulse 1 is issued straight from the accepting edge.
                        state_d      = StIssue;
                        vec_cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                        issue_key    = (key_every == KEY_W'(1));
                        key_load     = 1'b1;
                        key_load_val = (key_every <= KEY_W'(1)) ? '0 : key_every - KEY_W'(2);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_q == '0) begin
                    if (more_left) begin
                        state_d    = StIssue;
                        next_pulse = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    state_d      = StWait;
                    gap_load     = 1'b1;
                    gap_load_val = gap_q - 1'b1;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_expired) begin
                    if (more_left) begin
                        state_d    = StIssue;
                        next_pulse = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    gap_en = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (next_pulse) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
            issue_key = key_expired && (key_every_q != '0);
            if (key_expired) begin
                key_load     = 1'b1;
                key_load_val = key_every_q - 1'b1;
            end else begin
                key_en = 1'b1;
            end
        end
    end

    // Output decode from the next state, registered so all outputs align with the state.
    always_comb begin
        sc_d   = (state_d == StIssue);
        kc_d   = (state_d == StIssue) && issue_key;
        busy_d = (state_d == StIssue) || (state_d == StWait);
        done_d = (state_d == StDone);
    end

    assign state_change = sc_q;
    assign key_change   = kc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign vec_cnt      = vec_cnt_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: arithmetic campaign model checked every cycle, plus
// hand-computed pulse-cycle masks and counts per directed campaign.
module tb_stim_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] num_vectors = '0;
    logic [7:0]  gap = '0;
    logic [15:0] key_every = '0;
    logic        state_change, key_change, busy, done;
    logic [31:0] vec_cnt;

    stim_sequencer #(.CNT_W(32), .GAP_W(8), .KEY_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_vectors  (num_vectors),
        .gap          (gap),
        .key_every    (key_every),
        .state_change (state_change),
        .key_change   (key_change),
        .busy         (busy),
        .done         (done),
        .vec_cnt      (vec_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Campaign model: cycle index since acceptance and latched config.
    bit     m_act = 1'b0;
    longint m_t = 0, m_n = 0, m_p = 1, m_k = 0, m_ab = 0;

    // Per-campaign tallies of observed DUT behaviour, indexed by relative cycle.
    int       rc = 0;
    int       cnt_sc, cnt_kc, cnt_busy, cnt_done;
    bit [63:0] sc_mask, kc_mask, done_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_act = 1'b0;
        m_t   = 0;
        m_ab  = 0;
    endfunction

    function automatic void model_edge();
        longint last;
        bit     idle;
        if (!rst) begin
            model_reset();
            return;
        end
        last = (m_ab != 0) ? m_ab - 1 : m_n * m_p + 1;
        idle = !m_act || (m_t > last);
        if (!idle && abort) m_ab = m_t + 1;
        if (idle && start && !abort) begin
            m_n   = longint'(num_vectors);
            m_p   = longint'(gap) + 1;
            m_k   = longint'(key_every);
            m_t   = 1;
            m_ab  = 0;
            m_act = 1'b1;
        end else if (m_act) begin
            m_t++;
        end
    endfunction

    task automatic compare();
        bit     e_sc, e_kc, e_busy, e_done, live;
        longint n, c, e_vec;
        live   = m_act && !((m_ab != 0) && (m_t >= m_ab));
        e_sc   = live && (m_t <= m_n * m_p) && (((m_t - 1) % m_p) == 0);
        n      = (m_t - 1) / m_p + 1;
        e_kc   = e_sc && (m_k != 0) && ((n % (m_k == 0 ? 1 : m_k)) == 0);
        e_busy = live && (m_t <= m_n * m_p);
        e_done = live && (m_t == m_n * m_p + 1);
        e_vec  = 0;
        if (m_act) begin
            c = (m_ab != 0 && m_t >= m_ab) ? m_ab - 1 : m_t;
            if (c >= 1) e_vec = ((c - 1) / m_p + 1 < m_n) ? (c - 1) / m_p + 1 : m_n;
        end
        check("state_change", 64'(state_change), 64'(e_sc));
        check("key_change", 64'(key_change), 64'(e_kc));
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
        check("vec_cnt", 64'(vec_cnt), e_vec);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rc++;
        compare();
        if (state_change) begin cnt_sc++; if (rc < 64) sc_mask[rc] = 1'b1; end
        if (key_change) begin cnt_kc++; if (rc < 64) kc_mask[rc] = 1'b1; end
        if (busy) cnt_busy++;
        if (done) begin cnt_done++; if (rc < 64) done_mask[rc] = 1'b1; end
    endtask

    task automatic clear_tally();
        rc = 0; cnt_sc = 0; cnt_kc = 0; cnt_busy = 0; cnt_done = 0;
        sc_mask = '0; kc_mask = '0; done_mask = '0;
    endtask

    // Accepting edge ends relative cycle 0; config is scrambled afterwards.
    task automatic launch(input int unsigned n, input int unsigned g, input int unsigned k);
        num_vectors = n; gap = 8'(g); key_every = 16'(k); start = 1'b1;
        clear_tally();
        step();
        start = 1'b0;
        num_vectors = $urandom; gap = 8'($urandom); key_every = 16'($urandom);
    endtask

    task automatic run_to(input int target);
        while (rc < target) step();
    endtask

    initial begin
        clear_tally();
        step(); step();
        rst = 1'b1;
        step();

        // Async reset mid-campaign (pulse 2 visible in cycle 5).
        launch(10, 3, 0);
        run_to(5);
        check("pre_reset_pulse", 64'(state_change), 64'd1);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_state_change", 64'(state_change), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
        step(); step();
        rst = 1'b1;
        step(); step();
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_vec_cnt", 64'(vec_cnt), 64'd0);

        // N=4, gap=2: pulses 1,4,7,10, done 13, busy 1..12.
        launch(4, 2, 0);
        run_to(15);
        check("n4_sc_mask", sc_mask, 64'h0000_0000_0000_0492);
        check("n4_kc_cnt", 64'(cnt_kc), 64'd0);
        check("n4_done_mask", done_mask, 64'h0000_0000_0000_2000);
        check("n4_busy_cnt", 64'(cnt_busy), 64'd12);
        check("n4_vec_cnt", 64'(vec_cnt), 64'd4);

        // N=5, gap=0, key every 2: pulses 1..5, keys 2,4, done 6.
        launch(5, 0, 2);
        run_to(8);
        check("n5_sc_mask", sc_mask, 64'h0000_0000_0000_003E);
        check("n5_kc_mask", kc_mask, 64'h0000_0000_0000_0014);
        check("n5_done_mask", done_mask, 64'h0000_0000_0000_0040);
        check("n5_vec_cnt", 64'(vec_cnt), 64'd5);

        // N=0: done in cycle 1 only.
        launch(0, 5, 1);
        run_to(3);
        check("n0_sc_cnt", 64'(cnt_sc), 64'd0);
        check("n0_busy_cnt", 64'(cnt_busy), 64'd0);
        check("n0_done_mask", done_mask, 64'h0000_0000_0000_0002);

        // N=100, gap=1, abort sampled at the edge into cycle 7.
        launch(100, 1, 0);
        run_to(6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_to(12);
        check("ab_sc_mask", sc_mask, 64'h0000_0000_0000_002A);
        check("ab_done_cnt", 64'(cnt_done), 64'd0);
        check("ab_busy_cnt", 64'(cnt_busy), 64'd6);
        check("ab_vec_cnt", 64'(vec_cnt), 64'd3);

        // Abort and start together in idle: start must be refused.
        num_vectors = 2; gap = 0; key_every = 0; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        check("ab_start_busy", 64'(busy), 64'd0);
        check("ab_start_vec_cnt", 64'(vec_cnt), 64'd3);

        // N=3, gap=1 with start re-pulsed while busy; restart right after done.
        launch(3, 1, 0);
        run_to(3);
        start = 1'b1;
        run_to(5);
        start = 1'b0;
        run_to(8);
        check("rs_sc_cnt", 64'(cnt_sc), 64'd3);
        check("rs_done_mask", done_mask, 64'h0000_0000_0000_0080);
        num_vectors = 2; gap = 0; key_every = 1; start = 1'b1;
        step();
        start = 1'b0;
        check("rs_new_vec_cnt", 64'(vec_cnt), 64'd1);
        check("rs_new_key", 64'(key_change), 64'd1);
        repeat (4) step();
        check("rs_final_vec_cnt", 64'(vec_cnt), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
